// File: rtl/x2_vector_sweeper_pkg.sv
// x2_sweep_pkg: shared state type, default widths and the masked output compare
// Contents: X2_NI/X2_NO default widths, state_t (IDLE/RUN/DONE), masked_match()
package x2_sweep_pkg;
    localparam int X2_NI = 10;
    localparam int X2_NO = 7;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic logic masked_match(input logic [X2_NO-1:0] f, input logic [X2_NO-1:0] target, input logic [X2_NO-1:0] mask);
        return ((f ^ target) & mask) == '0;
    endfunction
endpackage

// File: rtl/x2_vector_sweeper_if.sv
// x2_vector_sweeper_if: control, result and core-facing signals of the vector sweeper
// Signals: start/mode/target/mask (control in), x_out/f_in (core drive/response),
//          busy/done/found/found_vec/match_cnt (status/results)
// Modports: master = controller/integration side, slave = sweeper
interface x2_vector_sweeper_if import x2_sweep_pkg::*; #(
    parameter int NI = X2_NI,
    parameter int NO = X2_NO
) ();
    logic          start;
    logic          mode;
    logic [NO-1:0] target;
    logic [NO-1:0] mask;
    logic [NI-1:0] x_out;
    logic [NO-1:0] f_in;
    logic          busy;
    logic          done;
    logic          found;
    logic [NI-1:0] found_vec;
    logic [NI:0]   match_cnt;
    modport master (
        output start, mode, target, mask, f_in,
        input  x_out, busy, done, found, found_vec, match_cnt
    );
    modport slave (
        input  start, mode, target, mask, f_in,
        output x_out, busy, done, found, found_vec, match_cnt
    );
endinterface

// File: rtl/x2_vector_sweeper.sv
// x2_vector_sweeper: enumerates every core input vector, counts masked output matches
// Ports: clk, rst (sync, active-high), bus (x2_vector_sweeper_if.slave)
// Params: NI core inputs, NO core outputs, HOLD cycles per vector before sampling f_in
module x2_vector_sweeper import x2_sweep_pkg::*; #(
    parameter int NI   = X2_NI,
    parameter int NO   = X2_NO,
    parameter int HOLD = 1
) (
    input logic                clk,
    input logic                rst,
    x2_vector_sweeper_if.slave bus
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          mode_q;
    logic [NO-1:0] target_q;
    logic [NO-1:0] mask_q;
    logic          hit;
    // x_out doubles as the sweep vector register, so the core sees a registered drive
    assign hit = masked_match(bus.f_in, target_q, mask_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            mode_q        <= 1'b0;
            target_q      <= '0;
            mask_q        <= '0;
            bus.x_out     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.found     <= 1'b0;
            bus.found_vec <= '0;
            bus.match_cnt <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state         <= RUN;
                    hold_cnt      <= '0;
                    mode_q        <= bus.mode;
                    target_q      <= bus.target;
                    mask_q        <= bus.mask;
                    bus.x_out     <= '0;
                    bus.busy      <= 1'b1;
                    bus.found     <= 1'b0;
                    bus.found_vec <= '0;
                    bus.match_cnt <= '0;
                end
                RUN: if (hold_cnt == HW'(HOLD - 1)) begin
                    if (hit) begin
                        bus.match_cnt <= bus.match_cnt + 1'b1;
                        if (!bus.found) begin
                            bus.found     <= 1'b1;
                            bus.found_vec <= bus.x_out;
                        end
                    end
                    // terminal vector always exits, so the vector never wraps
                    if ((mode_q && hit) || bus.x_out == '1) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        bus.x_out <= bus.x_out + 1'b1;
                        hold_cnt  <= '0;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    bus.x_out <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x2_vector_sweeper.sv
// tb_x2_vector_sweeper: randomized directed sweeps of two sweepers (HOLD=1, HOLD=3) against a table-driven core
module tb_x2_vector_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st1 = 1'b0;
    logic st3 = 1'b0;
    logic       mode = 1'b0;
    logic [6:0] target = '0;
    logic [6:0] mask = '0;
    logic [6:0] lut [1024];
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    x2_vector_sweeper_if b1 ();
    x2_vector_sweeper_if b3 ();
    assign b1.start  = st1;
    assign b1.mode   = mode;
    assign b1.target = target;
    assign b1.mask   = mask;
    assign b1.f_in   = lut[b1.x_out];
    assign b3.start  = st3;
    assign b3.mode   = mode;
    assign b3.target = target;
    assign b3.mask   = mask;
    assign b3.f_in   = lut[b3.x_out];
    x2_vector_sweeper #(.HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    x2_vector_sweeper #(.HOLD(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get(input int sel, input int what);
        case (what)
            0: return sel == 3 ? 32'(b3.busy) : 32'(b1.busy);
            1: return sel == 3 ? 32'(b3.done) : 32'(b1.done);
            2: return sel == 3 ? 32'(b3.found) : 32'(b1.found);
            3: return sel == 3 ? 32'(b3.found_vec) : 32'(b1.found_vec);
            4: return sel == 3 ? 32'(b3.match_cnt) : 32'(b1.match_cnt);
            default: return sel == 3 ? 32'(b3.x_out) : 32'(b1.x_out);
        endcase
    endfunction

    task automatic sweep(input string tag, input int sel, input logic m, input logic [6:0] t, input logic [6:0] k);
        int cnt = 0, first = -1, last, lat, edges = 0, bc;
        int hold = sel == 3 ? 3 : 1;
        for (int v = 0; v < 1024; v++)
            if (((lut[v] ^ t) & k) == 7'd0) begin
                cnt++;
                if (first < 0) first = v;
            end
        last = (m && first >= 0) ? first : 1023;
        if (m && first >= 0) cnt = 1;
        lat = (last + 1) * hold;
        @(negedge clk);
        mode = m; target = t; mask = k;
        if (sel == 3) st3 = 1'b1; else st1 = 1'b1;
        @(posedge clk);
        #1;
        st1 = 1'b0; st3 = 1'b0;
        // scramble inputs after the start edge; the sweep must use the latched copies
        mode = ~m; target = 7'($urandom); mask = 7'($urandom);
        bc = int'(get(sel, 0));
        while (edges < 5000) begin
            @(posedge clk);
            #1;
            edges++;
            if (get(sel, 1) == 1) break;
            bc += int'(get(sel, 0));
        end
        chk({tag, " latency"}, edges, lat);
        chk({tag, " busy_cycles"}, bc, lat);
        chk({tag, " busy_in_done"}, get(sel, 0), 0);
        chk({tag, " x_out_in_done"}, get(sel, 5), last);
        chk({tag, " match_cnt"}, get(sel, 4), cnt);
        chk({tag, " found"}, get(sel, 2), first >= 0 ? 1 : 0);
        chk({tag, " found_vec"}, get(sel, 3), first >= 0 ? first : 0);
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, get(sel, 1), 0);
        chk({tag, " x_out_idle"}, get(sel, 5), 0);
        chk({tag, " cnt_held"}, get(sel, 4), cnt);
    endtask

    initial begin
        logic [6:0] unsat, t;
        int dcount;
        for (int v = 0; v < 1024; v++) lut[v] = 7'($urandom);
        unsat = 7'($urandom);
        for (int v = 0; v < 1024; v++) if (lut[v] == unsat) lut[v] = unsat ^ 7'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", b1.busy, 0);
        chk("rst done", b1.done, 0);
        chk("rst found", b1.found, 0);
        chk("rst found_vec", b1.found_vec, 0);
        chk("rst match_cnt", b1.match_cnt, 0);
        chk("rst x_out", b1.x_out, 0);
        chk("rst x_out h3", b3.x_out, 0);
        @(negedge clk) rst = 1'b0;
        sweep("m0 rand", 1, 1'b0, 7'($urandom), 7'($urandom_range(1, 127)));
        sweep("m0 rand2", 1, 1'b0, 7'($urandom), 7'b0001001);
        sweep("m1 rand", 1, 1'b1, 7'($urandom), 7'b0000011);
        sweep("m1 rand h3", 3, 1'b1, 7'($urandom), 7'b0000101);
        sweep("m0 mask0", 1, 1'b0, 7'($urandom), 7'd0);
        sweep("m0 mask0 h3", 3, 1'b0, 7'($urandom), 7'd0);
        sweep("m1 mask0", 1, 1'b1, 7'($urandom), 7'd0);
        sweep("m0 unsat", 1, 1'b0, unsat, 7'h7f);
        sweep("m1 unsat", 1, 1'b1, unsat, 7'h7f);
        // mid-sweep start pulse and target toggles, then reset at RUN cycle 200
        @(negedge clk);
        mode = 1'b0; target = 7'($urandom); mask = 7'b0000011; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        dcount = 0;
        for (int c = 1; c < 200; c++) begin
            if (c == 50) st1 = 1'b1;
            if (c == 51) st1 = 1'b0;
            if (c % 17 == 0) target = ~target;
            @(negedge clk);
            dcount += int'(b1.done);
        end
        chk("robust no_done", dcount, 0);
        chk("robust busy_before_rst", b1.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("robust rst busy", b1.busy, 0);
        chk("robust rst done", b1.done, 0);
        chk("robust rst x_out", b1.x_out, 0);
        chk("robust rst found", b1.found, 0);
        chk("robust rst found_vec", b1.found_vec, 0);
        chk("robust rst match_cnt", b1.match_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("robust idle_after_rst", b1.done, 0);
        t = 7'($urandom);
        sweep("post_rst m0", 1, 1'b0, t, 7'b0000110);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
